stream_mux_rr: RTL and testbench
================================

# stream_mux_rr

Parametrised N-input, W-bit streaming multiplexer with a valid/ready handshake on every input and on the output. The output is registered. Each input can be picked by an explicit select (fixed mode) or by a fair round-robin arbiter (round-robin mode). It is the successor to the 8:1 single-bit combinational mux and is used wherever several producers share one downstream consumer.

## Interface
- `N_IN`, default 8: number of input channels, ≥2.
- `W`, default 8: data width per channel, ≥1.
- `SELW`, default `$clog2(N_IN)`: select and source-index width. Derived; do not override.
- `clk` input, 1: single clock. All logic is on the rising edge.
- `rst` input, 1: synchronous, active-high reset.
- `in_data` input, `N_IN*W`: channel *i* occupies bits `[i*W +: W]`.
- `in_valid` input, `N_IN`: per-channel valid.
- `in_ready` output, `N_IN`: per-channel ready. At most one bit is high in any cycle.
- `mode` input, 1: 0 = fixed select, 1 = round-robin.
- `sel` input, `SELW`: channel index, used in fixed mode only.
- `out_data` output, `W`: registered data.
- `out_src` output, `SELW`: index of the channel that supplied `out_data`.
- `out_valid` output, 1: output register holds a beat.
- `out_ready` input, 1: consumer accepts the beat.

## Operation
- **Output register.** A single stage that is either empty or full.
- **Load enable.** `load_en = !out_valid || out_ready`.
- **Candidate, fixed mode.** The candidate is `sel`. If `sel >= N_IN`, there is no candidate and all `in_ready` bits are 0.
- **Candidate, round-robin mode.** The candidate is the first channel with `in_valid=1`, searching upward from `rr_ptr` and wrapping from `N_IN-1` to 0. If no channel is valid, there is no candidate.
- **`in_ready`.**
  - `in_ready[c] = load_en` for the candidate channel `c`.
  - Every other `in_ready` bit is 0.
  - `in_ready` is combinational from `in_valid`, `mode`, `sel`, `rr_ptr` and `out_ready`.
- **Input transfer.** A transfer on channel *c* occurs when `in_valid[c] && in_ready[c]`. At that clock edge:
  - `out_data` ← channel *c* data.
  - `out_src` ← *c*.
  - `out_valid` ← 1.
- **Output drain.**
  - If `out_ready && out_valid` and there is no input transfer in the same cycle, then `out_valid` ← 0.
  - `out_data` and `out_src` hold their last values.
- **`rr_ptr`.**
  - Width `SELW`, reset value 0.
  - After a transfer in round-robin mode, `rr_ptr` ← (*c*+1) mod `N_IN`. The wrap must be correct for non-power-of-two `N_IN`.
  - In fixed mode, `rr_ptr` is unchanged.
- **Mode and select changes.**
  - Changes to `mode` or `sel` affect only the next selection. A held output beat is never altered.
  - The pointer is preserved across mode switches.
- **Reset.** On `rst=1`:
  - `out_valid`=0, `out_data`=0, `out_src`=0, `rr_ptr`=0.
  - `in_ready` is all 0 during the reset cycle.
  - Reset takes priority over any simultaneous transfer. A beat in flight is dropped.

## Timing
- **Latency.** 1 cycle from input transfer to `out_valid`=1.
- **Throughput.** One beat per cycle while `out_ready` is held at 1. Back-to-back transfers occur on different channels, or repeatedly on the same channel in fixed mode.
- **Backpressure.** With `out_ready`=0 and `out_valid`=1, all `in_ready` are 0 and the output holds stable. There is no data loss or duplication.
- **Simultaneous drain and load.** A drain and a load in the same cycle keep `out_valid`=1 with the new data, with no bubble.
- **Fairness.** In round-robin mode with all `N_IN` inputs continuously valid and `out_ready`=1, each channel is granted exactly once in every `N_IN` consecutive transfers.
- **No combinational paths** from `out_ready` to `out_data`, `out_src` or `out_valid`. The only combinational input-to-output paths are the ones into `in_ready`.

## Structure
- **Shared package `stream_mux_pkg`** contains:
  - Mode constants `MODE_FIXED`=1'b0 and `MODE_RR`=1'b1.
  - A `next_idx(idx, n)` function implementing the wrap-around increment.
- **Sub-module `rr_arbiter`.**
  - Parameter `N`.
  - Inputs: `req[N]`, `ptr[SELW]`.
  - Outputs: `gnt_idx[SELW]`, `gnt_vld`.
  - Purely combinational rotate-priority search.
  - Top-level `stream_mux_rr` owns `rr_ptr`, the mode select and the output register.

## Test plan
1. **Reset.** `rst` high for 2 cycles with all `in_valid`=1 → `out_valid`=0, `out_data`=0, `out_src`=0, `in_ready`=0 throughout.
2. **Fixed mode, default parameters.**
   - Stimulus: `mode`=0, `sel`=5, `in_data` channel 5 = 8'hA5, all valid, `out_ready`=1.
   - Required: only `in_ready[5]`=1. One cycle later `out_data`=8'hA5, `out_src`=5. Then sweep `sel` 0..7 and check each channel with a distinct value.
3. **Round-robin fairness.**
   - Stimulus: `mode`=1, all 8 valid, `out_ready`=1 for 16 cycles.
   - Required: `out_src` sequence 0,1,…,7,0,…,7.
   - Then drop `in_valid[2]` and `in_valid[3]` → the sequence skips 2 and 3: …1,4,5….
4. **Backpressure.**
   - Stimulus: `mode`=1, `out_ready`=0 for 5 cycles after the first beat.
   - Required: `out_valid`=1, and `out_data` and `out_src` are stable. All `in_ready`=0.
   - On `out_ready`=1, the next beat loads in the same cycle with no bubble.
   - A scoreboard sees no lost or duplicated beats.
5. **Odd width and count.** `N_IN`=5, `W`=12, round-robin mode, all valid → `out_src` wraps 4→0. `sel`=6 in fixed mode → no `in_ready`, `out_valid` stays 0.
6. **Mid-operation reset.** `rst` asserted while `out_valid`=1 and `rr_ptr`=3 → next cycle `out_valid`=0. The first round-robin grant after reset is channel 0.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// -----------------------------------------------------------------------------
// stream_mux_pkg
//   Shared definitions for the round-robin / fixed-select stream multiplexer.
//   - MODE_FIXED / MODE_RR : values of the top-level `mode` input.
//   - next_idx(idx, n)     : wrap-around increment, (idx + 1) mod n, written
//                            as a compare so it stays cheap for any n.
// -----------------------------------------------------------------------------
package stream_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Works for non-power-of-two n: the wrap happens at n-1, not at 2**width-1.
  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational rotate-priority search. Grants the first requester at
//   or above `ptr`, wrapping from N-1 back to 0.
//   Ports:
//     req     [N]    : request vector
//     ptr     [SELW] : highest-priority index this cycle
//     gnt_idx [SELW] : granted index (0 when nothing is granted)
//     gnt_vld        : at least one request was present
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N    = 8,
  parameter int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] gnt_idx,
  output logic            gnt_vld
);

  logic [SELW-1:0] idx;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      // Modulo by the elaboration-time constant N handles odd channel counts.
      idx = SELW'((int'(ptr) + k) % N);
      if (!gnt_vld && req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// -----------------------------------------------------------------------------
// stream_mux_rr
//   N_IN-input, W-bit valid/ready stream multiplexer with a single registered
//   output stage. The source is either an explicit `sel` (fixed mode) or a
//   fair round-robin arbiter (round-robin mode).
//   Ports:
//     clk, rst          : rising-edge clock, synchronous active-high reset
//     in_data [N_IN*W]  : channel i at [i*W +: W]
//     in_valid[N_IN]    : per-channel valid
//     in_ready[N_IN]    : per-channel ready, at most one bit high
//     mode              : MODE_FIXED / MODE_RR
//     sel     [SELW]    : channel index for fixed mode
//     out_data[W], out_src[SELW], out_valid : registered output beat
//     out_ready         : consumer accepts the beat
// -----------------------------------------------------------------------------
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int N_IN = 8,
  parameter int W    = 8,
  parameter int SELW = $clog2(N_IN)  // derived, do not override
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_IN*W-1:0] in_data,
  input  logic [N_IN-1:0]   in_valid,
  output logic [N_IN-1:0]   in_ready,
  input  logic              mode,
  input  logic [SELW-1:0]   sel,
  output logic [W-1:0]      out_data,
  output logic [SELW-1:0]   out_src,
  output logic              out_valid,
  input  logic              out_ready
);

  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    out_data_q,  out_data_d;
  logic [SELW-1:0] out_src_q,   out_src_d;
  logic [SELW-1:0] rr_ptr_q,    rr_ptr_d;

  logic [SELW-1:0] rr_gnt_idx;
  logic            rr_gnt_vld;
  logic [SELW-1:0] cand_idx;
  logic            cand_vld;
  logic [W-1:0]    cand_data;
  logic            cand_in_valid;
  logic            load_en;
  logic            xfer;

  rr_arbiter #(
    .N    (N_IN),
    .SELW (SELW)
  ) u_arb (
    .req     (in_valid),
    .ptr     (rr_ptr_q),
    .gnt_idx (rr_gnt_idx),
    .gnt_vld (rr_gnt_vld)
  );

  // The output stage can take a beat when it is empty or being drained now.
  assign load_en = !out_valid_q || out_ready;

  // Candidate selection. In fixed mode an out-of-range sel simply means
  // "nobody", which keeps every in_ready low.
  always_comb begin
    cand_idx = '0;
    cand_vld = 1'b0;
    if (mode == MODE_RR) begin
      cand_idx = rr_gnt_idx;
      cand_vld = rr_gnt_vld;
    end else begin
      cand_idx = sel;
      cand_vld = (int'(sel) < N_IN);
    end
  end

  // Compare-based mux: never indexes in_data with a value >= N_IN.
  always_comb begin
    cand_data     = '0;
    cand_in_valid = 1'b0;
    in_ready      = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (cand_vld && (int'(cand_idx) == i)) begin
        cand_data     = in_data[i*W +: W];
        cand_in_valid = in_valid[i];
        in_ready[i]   = load_en && !rst;
      end
    end
  end

  assign xfer = cand_vld && cand_in_valid && load_en && !rst;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    rr_ptr_d    = rr_ptr_q;
    if (xfer) begin
      // A load in the same cycle as a drain keeps out_valid high: no bubble.
      out_valid_d = 1'b1;
      out_data_d  = cand_data;
      out_src_d   = cand_idx;
      if (mode == MODE_RR) begin
        rr_ptr_d = SELW'(next_idx(32'(cand_idx), N_IN));
      end
    end else if (out_ready && out_valid_q) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// -----------------------------------------------------------------------------
// tb_stream_mux_rr
//   Two instances: A (N_IN=8, W=8) and B (N_IN=5, W=12). A behavioural model
//   predicts in_ready and pushes every expected beat into a per-instance
//   queue; a separate monitor pops and compares whenever out_valid is seen.
//   Timing per cycle (period 10, posedge at +5 after each negedge):
//     +2 stimulus driven, +3 model evaluates, +4 monitor samples.
// -----------------------------------------------------------------------------
module tb_stream_mux_rr;

  typedef struct {
    int unsigned data;
    int unsigned src;
  } beat_t;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus, index 0 = instance A, 1 = instance B.
  bit          rst_v [2];
  bit [7:0]    vld   [2];
  int unsigned dat   [2][8];
  bit          mode_v[2];
  int unsigned sel_v [2];
  bit          ordy  [2];

  // Reference model state.
  bit          m_full[2];
  int          m_ptr [2];
  beat_t       qa[$], qb[$];
  int unsigned log_a[$], log_b[$];
  bit          log_en[2];

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] a_in_data;
  logic [7:0]  a_in_valid, a_in_ready, a_out_data;
  logic        a_mode, a_out_valid, a_out_ready, a_rst;
  logic [2:0]  a_sel, a_out_src;

  logic [59:0] b_in_data;
  logic [4:0]  b_in_valid, b_in_ready;
  logic [11:0] b_out_data;
  logic        b_mode, b_out_valid, b_out_ready, b_rst;
  logic [2:0]  b_sel, b_out_src;

  always_comb begin
    a_in_data = '0;
    b_in_data = '0;
    for (int c = 0; c < 8; c++) a_in_data[c*8 +: 8] = dat[0][c][7:0];
    for (int c = 0; c < 5; c++) b_in_data[c*12 +: 12] = dat[1][c][11:0];
    a_in_valid  = vld[0];
    b_in_valid  = vld[1][4:0];
    a_mode      = mode_v[0];
    b_mode      = mode_v[1];
    a_sel       = sel_v[0][2:0];
    b_sel       = sel_v[1][2:0];
    a_out_ready = ordy[0];
    b_out_ready = ordy[1];
    a_rst       = rst_v[0];
    b_rst       = rst_v[1];
  end

  stream_mux_rr #(.N_IN(8), .W(8)) dut_a (
    .clk       (clk),
    .rst       (a_rst),
    .in_data   (a_in_data),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .mode      (a_mode),
    .sel       (a_sel),
    .out_data  (a_out_data),
    .out_src   (a_out_src),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready)
  );

  stream_mux_rr #(.N_IN(5), .W(12)) dut_b (
    .clk       (clk),
    .rst       (b_rst),
    .in_data   (b_in_data),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .mode      (b_mode),
    .sel       (b_sel),
    .out_data  (b_out_data),
    .out_src   (b_out_src),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int n_of(input int d);
    return (d == 0) ? 8 : 5;
  endfunction

  function automatic int unsigned mask_of(input int d);
    return (d == 0) ? 32'hFF : 32'hFFF;
  endfunction

  // Spec-level model: who may send this cycle, and what ends up in the output.
  task automatic model_step(input int d);
    int       n;
    int       cand;
    int       ch;
    bit       load_en;
    bit [7:0] exp_rdy;
    bit [7:0] dut_rdy;
    bit       dut_ov;
    beat_t    b;
    string    nm;
    nm      = (d == 0) ? "A" : "B";
    n       = n_of(d);
    cand    = -1;
    exp_rdy = '0;
    dut_rdy = (d == 0) ? a_in_ready : {3'b000, b_in_ready};
    dut_ov  = (d == 0) ? a_out_valid : b_out_valid;
    check({nm, " out_valid"}, dut_ov, m_full[d]);
    if (rst_v[d]) begin
      check({nm, " in_ready during reset"}, dut_rdy, 8'h00);
      m_full[d] = 1'b0;
      m_ptr[d]  = 0;
      if (d == 0) qa.delete(); else qb.delete();
      return;
    end
    load_en = !m_full[d] || ordy[d];
    if (mode_v[d] == 1'b0) begin
      if (sel_v[d] < n) cand = int'(sel_v[d]);
    end else begin
      for (int k = 0; k < n; k++) begin
        ch = (m_ptr[d] + k) % n;
        if (vld[d][ch]) begin
          cand = ch;
          break;
        end
      end
    end
    if (cand >= 0 && load_en) exp_rdy[cand] = 1'b1;
    check({nm, " in_ready"}, dut_rdy, exp_rdy);
    if (cand >= 0 && load_en && vld[d][cand]) begin
      b.data = dat[d][cand] & mask_of(d);
      b.src  = cand;
      if (d == 0) qa.push_back(b); else qb.push_back(b);
      m_full[d] = 1'b1;
      if (mode_v[d]) m_ptr[d] = (cand + 1) % n;
    end else if (ordy[d]) begin
      m_full[d] = 1'b0;
    end
  endtask

  task automatic tick();
    #1;
    model_step(0);
    model_step(1);
    @(posedge clk);
    @(negedge clk);
    #2;
  endtask

  task automatic mon(input int d);
    bit          ov;
    logic [63:0] od, os;
    beat_t       b;
    int          qsz;
    string       nm;
    nm  = (d == 0) ? "A" : "B";
    ov  = (d == 0) ? a_out_valid : b_out_valid;
    od  = (d == 0) ? 64'(a_out_data) : 64'(b_out_data);
    os  = (d == 0) ? 64'(a_out_src) : 64'(b_out_src);
    qsz = (d == 0) ? qa.size() : qb.size();
    if (rst_v[d] || !ov) return;
    if (qsz == 0) begin
      check({nm, " spurious out_valid"}, ov, 1'b0);
      return;
    end
    b = (d == 0) ? qa[0] : qb[0];
    check({nm, " out_data"}, od, 64'(b.data));
    check({nm, " out_src"},  os, 64'(b.src));
    if (ordy[d]) begin
      if (d == 0) begin
        void'(qa.pop_front());
        if (log_en[0]) log_a.push_back(32'(os));
      end else begin
        void'(qb.pop_front());
        if (log_en[1]) log_b.push_back(32'(os));
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #4;
      mon(0);
      mon(1);
    end
  end

  task automatic rand_data(input int d);
    for (int c = 0; c < 8; c++) dat[d][c] = $urandom & mask_of(d);
  endtask

  int exp_seq[22] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1, 2, 3, 4, 5, 6, 7, 0, 1, 4, 5, 6, 7};
  int unsigned sweep_val;

  initial begin
    rst_v  = '{1'b1, 1'b1};
    vld    = '{8'hFF, 8'h1F};
    mode_v = '{1'b0, 1'b0};
    sel_v  = '{0, 0};
    ordy   = '{1'b1, 1'b1};
    log_en = '{1'b0, 1'b0};
    m_full = '{1'b0, 1'b0};
    m_ptr  = '{0, 0};
    rand_data(0);
    rand_data(1);
    @(negedge clk);
    #2;

    // Reset held two cycles with every input valid.
    tick();
    tick();
    rst_v = '{1'b0, 1'b0};
    check("A reset out_data", a_out_data, 0);
    check("A reset out_src",  a_out_src,  0);
    check("B reset out_data", b_out_data, 0);
    check("B reset out_src",  b_out_src,  0);

    // Fixed mode on A, then a sweep over every channel.
    vld[1]    = '0;
    mode_v[0] = 1'b0;
    sel_v[0]  = 5;
    rand_data(0);
    dat[0][5] = 32'hA5;
    tick();
    check("A fixed sel5 data", a_out_data, 8'hA5);
    check("A fixed sel5 src",  a_out_src,  5);
    for (int c = 0; c < 8; c++) begin
      sel_v[0]  = c;
      sweep_val = (c * 37 + 11) & 32'hFF;
      dat[0][c] = sweep_val;
      tick();
      check("A sweep data", a_out_data, sweep_val);
      check("A sweep src",  a_out_src,  c);
    end

    // Round-robin fairness, then channels 2 and 3 dropped.
    mode_v[0] = 1'b1;
    sel_v[0]  = $urandom_range(0, 7);
    vld[0]    = 8'hFF;
    tick();
    log_a.delete();
    log_en[0] = 1'b1;
    repeat (15) begin rand_data(0); tick(); end
    vld[0] = 8'hF3;
    repeat (6) begin rand_data(0); tick(); end
    vld[0] = 8'h00;
    tick();
    log_en[0] = 1'b0;
    check("A rr sequence length", log_a.size(), 22);
    for (int i = 0; i < 22 && i < log_a.size(); i++) check("A rr sequence", log_a[i], exp_seq[i]);

    // Backpressure: stall five cycles with fresh data on every input.
    vld[0]  = 8'hFF;
    ordy[0] = 1'b1;
    tick();
    ordy[0] = 1'b0;
    repeat (5) begin rand_data(0); tick(); end
    ordy[0] = 1'b1;
    repeat (4) begin rand_data(0); tick(); end

    // Mid-operation reset with rr_ptr = 3 and a beat held.
    vld[0] = 8'h04;
    tick();
    ordy[0]  = 1'b0;
    vld[0]   = 8'hFF;
    rst_v[0] = 1'b1;
    tick();
    rst_v[0] = 1'b0;
    check("A out_valid after mid reset", a_out_valid, 1'b0);
    ordy[0] = 1'b1;
    tick();
    check("A first grant after reset", a_out_src, 0);
    vld[0] = 8'h00;
    tick();

    // Instance B: odd count and width, wrap 4 -> 0, then out-of-range sel.
    vld[1]    = 8'h1F;
    mode_v[1] = 1'b1;
    ordy[1]   = 1'b1;
    rand_data(1);
    tick();
    log_b.delete();
    log_en[1] = 1'b1;
    repeat (10) begin rand_data(1); tick(); end
    vld[1] = 8'h00;
    tick();
    log_en[1] = 1'b0;
    check("B rr sequence length", log_b.size(), 11);
    for (int i = 0; i < log_b.size(); i++) check("B rr sequence", log_b[i], i % 5);
    mode_v[1] = 1'b0;
    sel_v[1]  = 6;
    vld[1]    = 8'h1F;
    repeat (3) tick();
    check("B sel6 out_valid", b_out_valid, 1'b0);
    check("B sel6 in_ready",  b_in_ready,  5'b00000);

    // Randomised traffic on both instances.
    repeat (400) begin
      for (int d = 0; d < 2; d++) begin
        vld[d]    = $urandom & ((d == 0) ? 32'hFF : 32'h1F);
        mode_v[d] = $urandom_range(0, 1);
        sel_v[d]  = $urandom_range(0, 7);
        ordy[d]   = ($urandom_range(0, 3) != 0);
        rst_v[d]  = ($urandom_range(0, 99) == 0);
        rand_data(d);
      end
      tick();
    end

    // Drain and confirm nothing was lost.
    rst_v = '{1'b0, 1'b0};
    vld   = '{8'h00, 8'h00};
    ordy  = '{1'b1, 1'b1};
    repeat (3) tick();
    check("A beats left in scoreboard", qa.size(), 0);
    check("B beats left in scoreboard", qb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
